// File: rtl/rom_streamer_pkg.sv
// Shared types and widths for the ROM message streamer.
// State encoding plus the ROM address/data widths used by the parent wiring.
package rom_streamer_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_streamer.sv
// Streams MSG_LEN bytes from an external sync-read ROM; first byte valid 3 edges after start, 1 byte/3 cycles.
// Backpressure: o_data/o_valid hold while i_ready is low; i_start is ignored until the block is idle again.
module rom_streamer
  import rom_streamer_pkg::*;
#(
  parameter int MSG_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  state_t state;
  logic   xfer;

  assign xfer = o_valid & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      o_addr  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_addr <= '0;
            o_busy <= 1'b1;
            state  <= ST_FETCH;
          end
        end
        // ROM samples o_addr on the edge leaving FETCH, data arrives during LOAD
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          o_data  <= i_rom_data;
          o_valid <= 1'b1;
          state   <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer) begin
            o_valid <= 1'b0;
            // the last index stops the stream, so the address never wraps past 511
            if (o_addr == LAST_IDX) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              o_addr <= o_addr + 1'b1;
              state  <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_streamer.sv
// Two streamers (MSG_LEN 4 and 512) on shared stimulus, each checked every cycle against a message-level model.
module tb_rom_streamer;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic ready;
  int   edge_n = 0;
  int   m_tests = 0;
  int   m_fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int ML = (g == 0) ? 4 : 512;

    logic [8:0] addr;
    logic [7:0] rom_q;
    logic       valid;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic [7:0] mem [512];

    int tests = 0;
    int fails = 0;
    bit active = 1'b0;
    int idx = 0;
    int cnt = 0;
    logic [8:0] addr_exp = '0;
    bit done_exp;
    bit valid_exp;
    bit have_prev = 1'b0;
    bit p_start, p_ready, p_valid;
    logic [7:0] p_data;
    logic [8:0] p_addr;
    int xfers = 0;
    int dones = 0;
    int start_edge = 0;
    int valid_edge = 0;
    bit want_valid = 1'b0;
    int xfer_edge [4];
    logic [7:0] first_bytes [4];
    logic [7:0] last_data = '0;
    logic [8:0] last_addr = '0;

    rom_streamer #(.MSG_LEN(ML)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (start),
      .o_addr    (addr),
      .i_rom_data(rom_q),
      .o_valid   (valid),
      .i_ready   (ready),
      .o_data    (data),
      .o_busy    (busy),
      .o_done    (done)
    );

    initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
    end

    always @(posedge clk) rom_q <= mem[addr];

    task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
        fails++;
        $display("FAIL %s len=%0d edge=%0d: got %0h expected %0h", nm, ML, edge_n, act, exp);
      end
    endtask

    // Each negedge evaluates the posedge just passed, using what the DUT saw before it.
    always @(negedge clk) begin
      if (!rst_n) begin
        chk("reset_valid", int'(valid), 0);
        chk("reset_data", int'(data), 0);
        chk("reset_addr", int'(addr), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        active = 1'b0;
        idx = 0;
        cnt = 0;
        addr_exp = '0;
        have_prev = 1'b0;
        want_valid = 1'b0;
      end else begin
        if (have_prev) begin
          done_exp = 1'b0;
          if (active) begin
            cnt++;
            if (p_valid && p_ready) begin
              chk("xfer_data", int'(p_data), (idx & 8'hFF) ^ 8'hA5);
              xfers++;
              if (idx < 4) begin
                xfer_edge[idx] = edge_n;
                first_bytes[idx] = p_data;
              end
              last_data = p_data;
              last_addr = p_addr;
              idx++;
              cnt = 0;
              if (idx == ML) begin
                active = 1'b0;
                done_exp = 1'b1;
              end else begin
                addr_exp = 9'(idx);
              end
            end
          end else if (p_start) begin
            active = 1'b1;
            idx = 0;
            cnt = 0;
            addr_exp = '0;
            start_edge = edge_n;
            want_valid = 1'b1;
          end
          valid_exp = active && (cnt >= 2);
          chk("valid", int'(valid), int'(valid_exp));
          chk("busy", int'(busy), int'(active));
          chk("done", int'(done), int'(done_exp));
          chk("addr", int'(addr), int'(addr_exp));
          if (valid_exp) chk("held_data", int'(data), (idx & 8'hFF) ^ 8'hA5);
          if (done) dones++;
          if (want_valid && valid) begin
            valid_edge = edge_n;
            want_valid = 1'b0;
          end
        end
        p_start = start;
        p_ready = ready;
        p_valid = valid;
        p_data = data;
        p_addr = addr;
        have_prev = 1'b1;
      end
    end
  end

  task automatic mchk(input string nm, input int act, input int exp);
    m_tests++;
    if (act != exp) begin
      m_fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for both streamers to go idle; pat=1 applies 10 stall cycles out of every 13.
  task automatic wait_idle(input int budget, input bit pat);
    int n = 0;
    while ((inst[0].busy || inst[1].busy) && n < budget) begin
      if (pat) ready = (n % 13) >= 10;
      tick();
      n++;
    end
    if (pat) ready = 1'b1;
    mchk("idle_within_budget", int'(n < budget), 1);
  endtask

  task automatic wait_cond0(input int target_xfers, input int budget, input string nm);
    int n = 0;
    while (inst[0].xfers < target_xfers && n < budget) begin
      tick();
      n++;
    end
    mchk(nm, int'(n < budget), 1);
  endtask

  int x0, d0, x1, d1;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    mchk("idle_after_reset", int'(inst[0].busy | inst[1].busy), 0);

    // Free-running downstream: exact bytes, latency and spacing.
    ready = 1'b1;
    x0 = inst[0].xfers; d0 = inst[0].dones; x1 = inst[1].xfers; d1 = inst[1].dones;
    pulse_start();
    wait_idle(3000, 1'b0);
    tick();
    mchk("a_len4_xfers", inst[0].xfers - x0, 4);
    mchk("a_len4_dones", inst[0].dones - d0, 1);
    mchk("a_byte0", int'(inst[0].first_bytes[0]), 'hA5);
    mchk("a_byte1", int'(inst[0].first_bytes[1]), 'hA4);
    mchk("a_byte2", int'(inst[0].first_bytes[2]), 'hA7);
    mchk("a_byte3", int'(inst[0].first_bytes[3]), 'hA6);
    mchk("a_first_valid_edges", inst[0].valid_edge - inst[0].start_edge + 1, 3);
    mchk("a_first_xfer_edge", inst[0].xfer_edge[0] - inst[0].start_edge, 3);
    for (int i = 0; i < 3; i++)
      mchk("a_xfer_spacing", inst[0].xfer_edge[i+1] - inst[0].xfer_edge[i], 3);
    mchk("a_len512_xfers", inst[1].xfers - x1, 512);
    mchk("a_len512_dones", inst[1].dones - d1, 1);
    mchk("a_len512_last_data", int'(inst[1].last_data), 'h5A);
    mchk("a_len512_last_addr", int'(inst[1].last_addr), 511);

    // Heavy stalls: 10 low cycles out of 13.
    x0 = inst[0].xfers; d0 = inst[0].dones; x1 = inst[1].xfers; d1 = inst[1].dones;
    pulse_start();
    wait_idle(9000, 1'b1);
    tick();
    mchk("b_len4_xfers", inst[0].xfers - x0, 4);
    mchk("b_len4_dones", inst[0].dones - d0, 1);
    mchk("b_len512_xfers", inst[1].xfers - x1, 512);
    mchk("b_len512_dones", inst[1].dones - d1, 1);

    // Start pulses while byte 2 sits in SEND.
    x0 = inst[0].xfers; d0 = inst[0].dones; x1 = inst[1].xfers; d1 = inst[1].dones;
    pulse_start();
    wait_cond0(x0 + 2, 100, "c_reach_byte2");
    ready = 1'b0;
    begin
      int n = 0;
      while (!inst[0].valid && n < 20) begin
        tick();
        n++;
      end
      mchk("c_byte2_valid", int'(inst[0].valid), 1);
    end
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    ready = 1'b1;
    wait_idle(3000, 1'b0);
    tick();
    mchk("c_len4_xfers", inst[0].xfers - x0, 4);
    mchk("c_len4_dones", inst[0].dones - d0, 1);
    mchk("c_len512_xfers", inst[1].xfers - x1, 512);
    mchk("c_len512_dones", inst[1].dones - d1, 1);

    // Reset during LOAD of byte 1, then a clean restart.
    x0 = inst[0].xfers; d0 = inst[0].dones; d1 = inst[1].dones;
    pulse_start();
    wait_cond0(x0 + 1, 100, "d_reach_byte1");
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    mchk("d_len4_no_done", inst[0].dones - d0, 0);
    mchk("d_len512_no_done", inst[1].dones - d1, 0);
    mchk("d_idle_after_reset", int'(inst[0].busy | inst[1].busy), 0);
    x0 = inst[0].xfers; d0 = inst[0].dones; x1 = inst[1].xfers; d1 = inst[1].dones;
    pulse_start();
    wait_idle(3000, 1'b0);
    tick();
    mchk("d_restart_byte0", int'(inst[0].first_bytes[0]), 'hA5);
    mchk("d_len4_xfers", inst[0].xfers - x0, 4);
    mchk("d_len512_xfers", inst[1].xfers - x1, 512);
    mchk("d_len512_dones", inst[1].dones - d1, 1);

    // Random ready and start traffic.
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      tick();
    end
    start = 1'b0;
    ready = 1'b1;
    wait_idle(3000, 1'b0);

    // start held high: back-to-back messages restarting from index 0.
    d0 = inst[0].dones;
    start = 1'b1;
    repeat (40) tick();
    start = 1'b0;
    wait_idle(3000, 1'b0);
    tick();
    mchk("f_held_start_restarts", int'(inst[0].dones - d0 >= 2), 1);

    $display("[TB] %0d tests run, %0d failed",
             m_tests + inst[0].tests + inst[1].tests,
             m_fails + inst[0].fails + inst[1].fails);
    $finish;
  end

endmodule
